regbank_arbiter: RTL and testbench

REGBANK_ARBITER -- requirements
Module: regbank_arbiter

---
 rtl/regbank_arbiter_pkg.sv | 19 +
 rtl/regbank_8x16.sv | 31 +++
 rtl/regbank_arbiter.sv | 109 ++++++++++
 tb/tb_regbank_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/regbank_arbiter_pkg.sv
// Shared sizing defaults and requester encoding for the register-bank arbiter.
package regbank_arbiter_pkg;

  localparam int NREG_DEF     = 8;
  localparam int DW_DEF       = 16;
  localparam int MAX_LOCK_DEF = 4;
  localparam int AW           = 3;

  typedef enum logic {
    RQ_CPU = 1'b0,
    RQ_DBG = 1'b1
  } rq_id_e;

  // Register indices beyond the populated bank are treated as holes.
  function automatic logic addr_ok(input logic [AW-1:0] a, input int nreg);
    return int'(a) < nreg;
  endfunction

endpackage

// File: rtl/regbank_8x16.sv
// Register storage: one write port, one combinational read port, flattened view.
module regbank_8x16
  import regbank_arbiter_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [DW-1:0]        wdata_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [DW-1:0]        rdata_o,
  output logic [NREG*DW-1:0]   matrix_o
);

  logic [NREG-1:0][DW-1:0] mem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
    end else if (we_i && addr_ok(waddr_i, NREG)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o  = addr_ok(raddr_i, NREG) ? mem_q[raddr_i] : '0;
  assign matrix_o = mem_q;

endmodule

// File: rtl/regbank_arbiter.sv
// Two-requester round-robin arbiter with requester-0 lock, in front of a
// register bank; reads return registered data with a one-cycle valid pulse.
module regbank_arbiter
  import regbank_arbiter_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [AW-1:0]      addr0,
  input  logic [AW-1:0]      addr1,
  input  logic [DW-1:0]      wdata0,
  input  logic [DW-1:0]      wdata1,
  input  logic               lock0,
  output logic               gnt0,
  output logic               gnt1,
  output logic               rvalid0,
  output logic               rvalid1,
  output logic [DW-1:0]      rdata0,
  output logic [DW-1:0]      rdata1,
  output logic [NREG*DW-1:0] regbank_matrix
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  rq_id_e        ptr_q;
  logic          lock_act_q;
  logic [CW-1:0] lock_cnt_q;
  logic          rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  logic          g0, g1;
  logic          bank_we;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_wdata, bank_rdata;

  // Lock only wins contention while requester 0 was granted last cycle with
  // lock0 set; otherwise the pointer decides.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst) begin
      if (req0 && req1) begin
        if (lock_act_q && (lock_cnt_q < CW'(MAX_LOCK))) g0 = 1'b1;
        else if (ptr_q == RQ_CPU)                        g0 = 1'b1;
        else                                             g1 = 1'b1;
      end else begin
        g0 = req0;
        g1 = req1;
      end
    end
  end

  assign bank_we    = (g0 & we0) | (g1 & we1);
  assign bank_addr  = g1 ? addr1  : addr0;
  assign bank_wdata = g1 ? wdata1 : wdata0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= RQ_CPU;
      lock_act_q <= 1'b0;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      if (g0)      ptr_q <= RQ_DBG;
      else if (g1) ptr_q <= RQ_CPU;

      lock_act_q <= g0 & lock0;

      if (g1 || !lock0)
        lock_cnt_q <= '0;
      else if (g0 && req1 && (lock_cnt_q < CW'(MAX_LOCK)))
        lock_cnt_q <= lock_cnt_q + CW'(1);

      rvalid0_q <= g0 & ~we0;
      rvalid1_q <= g1 & ~we1;
      if (g0 && !we0) rdata0_q <= bank_rdata;
      if (g1 && !we1) rdata1_q <= bank_rdata;
    end
  end

  regbank_8x16 #(.NREG(NREG), .DW(DW)) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we_i     (bank_we),
    .waddr_i  (bank_addr),
    .wdata_i  (bank_wdata),
    .raddr_i  (bank_addr),
    .rdata_o  (bank_rdata),
    .matrix_o (regbank_matrix)
  );

  assign gnt0    = g0;
  assign gnt1    = g1;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench: vector table for arbitration/read/write, plus hand sequences
// for lock, mid-stream reset and out-of-range addresses (6-register instance).
module tb_regbank_arbiter;
  import regbank_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int NREG = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0;
  logic [2:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;

  logic gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [NREG*DW-1:0] matrix;

  logic s_gnt0, s_gnt1, s_rv0, s_rv1;
  logic [DW-1:0] s_rd0, s_rd1;
  logic [6*DW-1:0] s_matrix;

  always #5 clk = ~clk;

  regbank_arbiter #(.NREG(NREG), .DW(DW), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .lock0(lock0),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .regbank_matrix(matrix)
  );

  regbank_arbiter #(.NREG(6), .DW(DW), .MAX_LOCK(4)) dut6 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .lock0(lock0),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .rvalid0(s_rv0), .rvalid1(s_rv1),
    .rdata0(s_rd0), .rdata1(s_rd1), .regbank_matrix(s_matrix)
  );

  typedef struct {
    logic r0, r1, w0, w1, lk;
    logic [2:0] a0, a1;
    logic [15:0] d0, d1;
    logic eg0, eg1, erv0, erv1;
    logic [15:0] erd0, erd1;
    int ci;
    logic [15:0] cv;
  } vec_t;

  vec_t tv[12];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r0_, input logic r1_, input logic w0_, input logic w1_,
                     input logic lk_, input logic [2:0] a0_, input logic [2:0] a1_,
                     input logic [15:0] d0_, input logic [15:0] d1_);
    req0 = r0_; req1 = r1_; we0 = w0_; we1 = w1_; lock0 = lk_;
    addr0 = a0_; addr1 = a1_; wdata0 = d0_; wdata1 = d1_;
  endtask

  function automatic vec_t mk(input logic r0, r1, w0, w1, lk, input logic [2:0] a0, a1,
                              input logic [15:0] d0, d1, input logic eg0, eg1, erv0, erv1,
                              input logic [15:0] erd0, erd1, input int ci, input logic [15:0] cv);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.lk = lk; v.a0 = a0; v.a1 = a1;
    v.d0 = d0; v.d1 = d1; v.eg0 = eg0; v.eg1 = eg1; v.erv0 = erv0; v.erv1 = erv1;
    v.erd0 = erd0; v.erd1 = erd1; v.ci = ci; v.cv = cv;
    return v;
  endfunction

  logic [0:12] lk_pat;
  logic [NREG*DW-1:0] exp_bank;

  initial begin
    //              r0 r1 w0 w1 lk a0 a1  d0       d1       g0 g1 v0 v1 rd0      rd1      ci cv
    tv[0]  = mk(0, 1, 0, 1, 0, 0, 3, 16'h0000, 16'h1234, 0, 1, 0, 0, 16'h0000, 16'h0000, 3, 16'h1234);
    tv[1]  = mk(1, 1, 0, 0, 0, 3, 3, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h1234, 16'h0000, 3, 16'h1234);
    tv[2]  = mk(0, 1, 0, 0, 0, 3, 3, 16'h0000, 16'h0000, 0, 1, 0, 1, 16'h1234, 16'h1234, -1, 16'h0);
    tv[3]  = mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h1234, 16'h1234, -1, 16'h0);
    tv[4]  = mk(1, 1, 1, 1, 0, 0, 1, 16'h1111, 16'h2222, 1, 0, 0, 0, 16'h1234, 16'h1234, 0, 16'h1111);
    tv[5]  = mk(1, 1, 1, 1, 0, 2, 1, 16'h3333, 16'h2222, 0, 1, 0, 0, 16'h1234, 16'h1234, 1, 16'h2222);
    tv[6]  = mk(1, 1, 1, 1, 0, 2, 4, 16'h3333, 16'h4444, 1, 0, 0, 0, 16'h1234, 16'h1234, 2, 16'h3333);
    tv[7]  = mk(1, 1, 1, 1, 0, 6, 4, 16'h6666, 16'h4444, 0, 1, 0, 0, 16'h1234, 16'h1234, 4, 16'h4444);
    tv[8]  = mk(1, 0, 1, 0, 0, 6, 0, 16'h6666, 16'h0000, 1, 0, 0, 0, 16'h1234, 16'h1234, 6, 16'h6666);
    tv[9]  = mk(1, 0, 1, 0, 0, 5, 0, 16'h00FF, 16'h0000, 1, 0, 0, 0, 16'h1234, 16'h1234, 5, 16'h00FF);
    tv[10] = mk(1, 0, 0, 0, 0, 5, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h00FF, 16'h1234, -1, 16'h0);
    tv[11] = mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h00FF, 16'h1234, -1, 16'h0);

    // Reset with both requesting: no grants, everything cleared.
    drv(1, 1, 1, 1, 0, 3'd1, 3'd2, 16'hAAAA, 16'h5555);
    #1 rst = 1'b0;
    #1;
    chk("rst_gnt0", 128'(gnt0), 128'(1'b0));
    chk("rst_gnt1", 128'(gnt1), 128'(1'b0));
    @(posedge clk); #1;
    chk("rst_matrix", 128'(matrix), 128'(0));
    chk("rst_rvalid", 128'({rvalid0, rvalid1}), 128'(2'b00));
    chk("rst_rdata", 128'({rdata0, rdata1}), 128'(0));
    drv(0, 0, 0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drv(tv[i].r0, tv[i].r1, tv[i].w0, tv[i].w1, tv[i].lk, tv[i].a0, tv[i].a1, tv[i].d0, tv[i].d1);
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 128'({gnt0, gnt1}), 128'({tv[i].eg0, tv[i].eg1}));
      @(posedge clk); #1;
      chk($sformatf("v%0d_rvalid", i), 128'({rvalid0, rvalid1}), 128'({tv[i].erv0, tv[i].erv1}));
      chk($sformatf("v%0d_rdata", i), 128'({rdata0, rdata1}), 128'({tv[i].erd0, tv[i].erd1}));
      if (tv[i].ci >= 0)
        chk($sformatf("v%0d_reg%0d", i, tv[i].ci), 128'(matrix[tv[i].ci*DW +: DW]), 128'(tv[i].cv));
    end
    exp_bank = {16'h0000, 16'h6666, 16'h00FF, 16'h4444, 16'h1234, 16'h3333, 16'h2222, 16'h1111};
    chk("bank_after_table", 128'(matrix), 128'(exp_bank));

    // Lock: pointer favours 1 at entry, then four locked gnt0 per gnt1; lock0=0 restores alternation.
    lk_pat = 13'b0111101111010;
    for (int c = 0; c < 13; c++) begin
      drv(1, 1, 0, 0, (c < 11), 3'd0, 3'd1, 16'h0, 16'h0);
      @(negedge clk);
      chk($sformatf("lock_c%0d_gnt", c), 128'({gnt0, gnt1}), 128'({lk_pat[c], ~lk_pat[c]}));
      @(posedge clk); #1;
    end

    // Mid-stream reset with a read result pending and a write request presented.
    drv(0, 1, 0, 0, 0, 3'd0, 3'd3, 16'h0, 16'h0);
    @(negedge clk);
    chk("pre_rst_gnt1", 128'(gnt1), 128'(1'b1));
    @(posedge clk); #1;
    chk("pre_rst_rv1", 128'({rvalid1, rdata1}), 128'({1'b1, 16'h1234}));
    drv(1, 0, 1, 0, 0, 3'd7, 3'd0, 16'hBEEF, 16'h0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_gnt", 128'({gnt0, gnt1}), 128'(2'b00));
    chk("mid_rst_rd1", 128'({rvalid1, rdata1}), 128'(0));
    @(posedge clk); #1;
    chk("mid_rst_matrix", 128'(matrix), 128'(0));
    chk("mid_rst_out0", 128'({gnt0, rvalid0, rdata0}), 128'(0));
    @(posedge clk); #1;
    drv(0, 0, 0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_r7", 128'(matrix[7*DW +: DW]), 128'(16'h0000));

    // Out-of-range index on the 6-register instance; full bank on the default one.
    drv(1, 0, 1, 0, 0, 3'd7, 3'd0, 16'hBEEF, 16'h0);
    @(negedge clk);
    chk("oor_wr_gnt", 128'({gnt0, s_gnt0}), 128'(2'b11));
    @(posedge clk); #1;
    chk("oor_wr_r7", 128'(matrix[7*DW +: DW]), 128'(16'hBEEF));
    chk("oor_wr_ignored", 128'(s_matrix), 128'(0));
    drv(1, 0, 0, 0, 0, 3'd7, 3'd0, 16'h0, 16'h0);
    @(posedge clk); #1;
    chk("oor_rd_full", 128'({rvalid0, rdata0}), 128'({1'b1, 16'hBEEF}));
    chk("oor_rd_small", 128'({s_rv0, s_rd0}), 128'({1'b1, 16'h0000}));
    drv(0, 1, 0, 0, 0, 3'd0, 3'd6, 16'h0, 16'h0);
    @(posedge clk); #1;
    chk("oor_rd6_small", 128'({s_rv1, s_rd1}), 128'({1'b1, 16'h0000}));
    drv(0, 0, 0, 0, 0, 3'd0, 3'd0, 16'h0, 16'h0);
    @(posedge clk); #1;
    chk("oor_rv_drop", 128'({s_rv0, s_rv1, rvalid0, rvalid1}), 128'(4'b0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
